// File: rtl/gray_step_counter.sv
// Up/down binary counter with a registered Gray copy, wrap/limit flags and a sticky
// single-bit-change checker on successive Gray codes. Latency 1 clock; no backpressure.
module gray_step_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             at_limit,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] gray_prev_q, gray_prev_d;
  logic             tc_q, tc_d;
  logic             at_limit_q, at_limit_d;
  logic             stepped_q, stepped_d;
  logic             step_err_q, step_err_d;
  logic [WIDTH-1:0] gray_diff;
  logic             one_bit_change;

  always_comb begin
    bin_d      = bin_q;
    tc_d       = 1'b0;
    at_limit_d = 1'b0;
    stepped_d  = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up) begin
        if (bin_q == MAX_VAL) begin
          if (WRAP) begin
            bin_d     = '0;
            tc_d      = 1'b1;
            stepped_d = 1'b1;
          end else begin
            // Saturated: flag only the first held cycle.
            tc_d       = ~at_limit_q;
            at_limit_d = 1'b1;
          end
        end else begin
          bin_d     = bin_q + 1'b1;
          stepped_d = 1'b1;
        end
      end else begin
        if (bin_q == '0) begin
          if (WRAP) begin
            bin_d     = MAX_VAL;
            tc_d      = 1'b1;
            stepped_d = 1'b1;
          end else begin
            tc_d       = ~at_limit_q;
            at_limit_d = 1'b1;
          end
        end else begin
          bin_d     = bin_q - 1'b1;
          stepped_d = 1'b1;
        end
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // Checks the registered code against the one it replaced, one cycle after the step.
  always_comb begin
    gray_prev_d    = gray_q;
    gray_diff      = gray_q ^ gray_prev_q;
    one_bit_change = (gray_diff != '0) && ((gray_diff & (gray_diff - 1'b1)) == '0);
    step_err_d     = step_err_q | (stepped_q & ~one_bit_change);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q       <= '0;
      gray_q      <= '0;
      gray_prev_q <= '0;
      tc_q        <= 1'b0;
      at_limit_q  <= 1'b0;
      stepped_q   <= 1'b0;
      step_err_q  <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      gray_q      <= gray_d;
      gray_prev_q <= gray_prev_d;
      tc_q        <= tc_d;
      at_limit_q  <= at_limit_d;
      stepped_q   <= stepped_d;
      step_err_q  <= step_err_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign tc       = tc_q;
  assign at_limit = at_limit_q;
  assign step_err = step_err_q;

endmodule
